serial_add_sequencer: RTL and testbench

//  Bit-serial adder controller. Time-shares one 1-bit adder cell (two half adders

---
 rtl/serial_add_sequencer.sv | 104 ++++++++++
 tb/tb_serial_add_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sequencer.sv
// Bit-serial adder controller: one full-adder cell time-shared LSB first.
// start/busy/done handshake; {cout,sum} = a + b + cin after WIDTH cycles.
module serial_add_sequencer #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             c_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             busy_q;
  logic             done_q;
  logic             cout_q;

  logic ha1_s;
  logic ha1_c;
  logic s_d;
  logic c_d;

  // Full adder built from two half adders plus an OR for the carry.
  always_comb begin
    ha1_s = a_q[0] ^ b_q[0];
    ha1_c = a_q[0] & b_q[0];
    s_d   = ha1_s ^ c_q;
    c_d   = ha1_c | (ha1_s & c_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            c_q     <= cin;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q <= {s_d, sum_q[WIDTH-1:1]};
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          c_q   <= c_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            cout_q  <= c_d;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Self-checking bench for serial_add_sequencer (WIDTH=8).
// Vector table, hand-written corner sequences, and random ops vs. arithmetic model.
module tb_serial_add_sequencer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  serial_add_sequencer #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         co;
  } vec_t;

  vec_t vecs[7];

  // Runs one op from IDLE; scrambles operands after accept; checks the
  // done pulse width and that sum/cout hold into IDLE.
  task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic vc, output logic [W-1:0] rs,
                        output logic rc, output int lat, output int bc);
    @(negedge clk);
    a = va; b = vb; cin = vc; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    lat = -1;
    bc  = 0;
    for (int k = 0; k < W + 4; k++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) begin
        lat = k;
        break;
      end
    end
    rs = sum;
    rc = cout;
    @(negedge clk);
    chk("done_width", 32'(done), 32'd0);
    chk("busy_after", 32'(busy), 32'd0);
    chk("sum_held", 32'(sum), 32'(rs));
    chk("cout_held", 32'(cout), 32'(rc));
  endtask

  logic [W-1:0] rs;
  logic         rc;
  int           lat;
  int           bc;
  logic [W:0]   ref_v;
  int           dcnt;

  initial begin
    vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    vecs[3] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[6] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, rs, rc, lat, bc);
      chk("vec_lat", 32'(lat), 32'(W));
      chk("vec_busy", 32'(bc), 32'(W + 1));
      chk("vec_sum", 32'(rs), 32'(vecs[i].s));
      chk("vec_cout", 32'(rc), 32'(vecs[i].co));
    end

    // Reset during the third bit aborts the op with no done pulse.
    @(negedge clk);
    a = 8'hFF; b = 8'h01; cin = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    chk("mid_rst_sum", 32'(sum), 32'd0);
    chk("mid_rst_cout", 32'(cout), 32'd0);
    rst = 1'b0;
    dcnt = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    chk("mid_rst_no_done", 32'(dcnt), 32'd0);

    // Start pulsed at E0+3 with new operands is ignored.
    @(negedge clk);
    a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    for (int k = 0; k < W + 4; k++) begin
      @(negedge clk);
      if (k == 2) begin
        start = 1'b1; a = 8'h11; b = 8'h11;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        lat = k;
        break;
      end
    end
    chk("ign_lat", 32'(lat), 32'(W));
    chk("ign_sum", 32'(sum), 32'h03);
    chk("ign_cout", 32'(cout), 32'd0);
    repeat (2) @(negedge clk);
    chk("ign_no_restart", 32'(busy), 32'd0);
    chk("ign_sum_held", 32'(sum), 32'h03);

    // Start held high: second op accepted at E0+10.
    @(negedge clk);
    a = 8'h3C; b = 8'h0F; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    lat = -1;
    for (int k = 0; k < 2 * W + 8; k++) begin
      @(negedge clk);
      if (k == W) begin
        chk("held_done1", 32'(done), 32'd1);
        chk("held_sum1", 32'({cout, sum}), 32'h04B);
        a = 8'h22; b = 8'h33; cin = 1'b1;
      end
      if (k == W + 1) chk("held_idle", 32'(busy), 32'd0);
      if (k == W + 2) begin
        chk("held_reaccept", 32'(busy), 32'd1);
        start = 1'b0;
      end
      if (k > W + 2 && done) begin
        lat = k;
        break;
      end
    end
    chk("held_lat2", 32'(lat), 32'(2 * W + 2));
    chk("held_sum2", 32'({cout, sum}), 32'h056);
    @(negedge clk);

    // Random ops with random gaps against a + b + cin.
    for (int n = 0; n < 1000; n++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rci;
      int           gap;
      ra  = W'($urandom);
      rb  = W'($urandom);
      rci = 1'($urandom);
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        chk("rnd_gap_done", 32'(done), 32'd0);
      end
      ref_v = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rci};
      run_op(ra, rb, rci, rs, rc, lat, bc);
      chk("rnd_lat", 32'(lat), 32'(W));
      chk("rnd_result", 32'({rc, rs}), 32'(ref_v));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
